// File: rtl/chess_eval_pkg.sv
// Shared types and constants for the evaluation unit: piece codes, board
// geometry, accumulator widths, sequencer states and the square decoder.
package chess_eval_pkg;

  localparam int VAL_W_DEF = 6;
  localparam int ACC_W_DEF = 13;
  localparam int COLOR_BIT = 3;
  localparam logic [5:0] SQ_MIRROR = 6'd56;

  typedef enum logic [2:0] {
    PT_EMPTY    = 3'd0,
    PT_PAWN     = 3'd1,
    PT_KNIGHT   = 3'd2,
    PT_BISHOP   = 3'd3,
    PT_ROOK     = 3'd4,
    PT_QUEEN    = 3'd5,
    PT_KING     = 3'd6,
    PT_RESERVED = 3'd7
  } piece_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    logic        valid;
    piece_type_e ptype;
    logic [5:0]  sq;
    logic        negate;
  } pst_req_t;

  // Empty and reserved codes produce no lookup; black squares flip rank
  // so both colours share the white-oriented tables.
  function automatic pst_req_t decode_square(input logic [3:0] code,
                                             input logic [5:0] sq);
    pst_req_t r;
    r = '0;
    if (code[2:0] inside {[3'd1:3'd6]}) begin
      r.valid  = 1'b1;
      r.ptype  = piece_type_e'(code[2:0]);
      r.sq     = code[COLOR_BIT] ? (sq ^ SQ_MIRROR) : sq;
      r.negate = code[COLOR_BIT];
    end
    return r;
  endfunction

endpackage

// File: rtl/pst_eval_sequencer_if.sv
// Lookup channel between the sequencer (master) and the PST ROM port (slave).
interface pst_eval_sequencer_if #(
  parameter int VAL_W = chess_eval_pkg::VAL_W_DEF
) ();

  logic                    pst_req_valid;
  logic [2:0]              pst_type;
  logic [5:0]              pst_sq;
  logic signed [VAL_W-1:0] pst_val;

  modport master (output pst_req_valid, pst_type, pst_sq, input pst_val);
  modport slave  (input pst_req_valid, pst_type, pst_sq, output pst_val);

endinterface

// File: rtl/pst_lookup_port.sv
// Registered one-cycle mux over the six flattened piece-square map buses;
// entry i of a map occupies bits [VAL_W*i +: VAL_W].
module pst_lookup_port
  import chess_eval_pkg::*;
#(
  parameter int VAL_W = VAL_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [64*VAL_W-1:0]    map [6],
  pst_eval_sequencer_if.slave    pst
);

  logic signed [VAL_W-1:0] val_q, val_d;
  logic [2:0]              map_sel;

  assign map_sel = pst.pst_type - 3'd1;

  always_comb begin
    // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
    val_d = val_q;
    if (pst.pst_req_valid && (pst.pst_type inside {[3'd1:3'd6]})) begin
      val_d = map[map_sel][pst.pst_sq*VAL_W +: VAL_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) val_q <= '0;
    else       val_q <= val_d;
  end

  assign pst.pst_val = val_q;

endmodule

// File: rtl/pst_eval_sequencer.sv
// Walks a latched 64-square board snapshot, issues one PST lookup per occupied
// square and accumulates the returned values (black negated) into a score.
module pst_eval_sequencer
  import chess_eval_pkg::*;
#(
  parameter int VAL_W   = VAL_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int PST_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [255:0]            board,
  pst_eval_sequencer_if.master    pst,
  output logic                    busy,
  output logic                    done,
  output logic signed [ACC_W-1:0] score
);

  if (PST_LAT != 1) begin : g_lat_check
    $error("pst_eval_sequencer supports only PST_LAT == 1");
  end

  seq_state_e              state_q, state_d;
  logic [255:0]            snap_q, snap_d;
  logic [5:0]              sq_q, sq_d, sq_next;
  logic signed [ACC_W-1:0] acc_q, acc_d, score_q, score_d;
  logic                    busy_q, busy_d, done_q, done_d;
  pst_req_t                req_q, req_d;
  logic                    pipe_valid_q, pipe_valid_d;
  logic                    pipe_neg_q, pipe_neg_d;
  logic signed [VAL_W-1:0] val_in;
  logic signed [ACC_W-1:0] val_ext;

  assign val_in  = pst.pst_val;
  assign val_ext = ACC_W'(val_in);
  assign sq_next = sq_q + 6'd1;

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    sq_d         = sq_q;
    score_d      = score_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    req_d        = '0;
    // The side pipe mirrors the lookup port's one-cycle latency.
    pipe_valid_d = req_q.valid;
    pipe_neg_d   = req_q.negate;
    acc_d        = acc_q;
    if (pipe_valid_q) acc_d = pipe_neg_q ? (acc_q - val_ext) : (acc_q + val_ext);

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_ISSUE;
          snap_d  = board;
          sq_d    = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          req_d   = decode_square(board[3:0], 6'd0);
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          pipe_valid_d = 1'b0;
        end else if (sq_q == 6'd63) begin
          state_d = ST_DRAIN;
        end else begin
          sq_d  = sq_next;
          req_d = decode_square(snap_q[{sq_next, 2'b00} +: 4], sq_next);
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          pipe_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          score_d = acc_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      snap_q       <= '0;
      sq_q         <= '0;
      acc_q        <= '0;
      score_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      req_q        <= '0;
      pipe_valid_q <= 1'b0;
      pipe_neg_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      sq_q         <= sq_d;
      acc_q        <= acc_d;
      score_q      <= score_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      req_q        <= req_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_neg_q   <= pipe_neg_d;
    end
  end

  assign pst.pst_req_valid = req_q.valid;
  assign pst.pst_type      = req_q.ptype;
  assign pst.pst_sq        = req_q.sq;
  assign busy              = busy_q;
  assign done              = done_q;
  assign score             = score_q;

endmodule

// File: doc/pst_eval_sequencer.md
Name: pst_eval_sequencer

Overview:
Sequences one piece-square-table (PST) positional evaluation over a full board snapshot. It walks all 64 squares, one per cycle, and issues a lookup per occupied square to a shared, registered PST lookup port that wraps the per-piece map ROMs. It mirrors and negates black pieces, then accumulates a signed positional score. It sits between the search controller and the PST ROM bank inside the evaluation unit.

Parameters:
VAL_W, 6, width of one signed PST entry as stored in the map ROMs.
ACC_W, 13, width of the signed score accumulator; covers 64 × (−32..31) without overflow.
PST_LAT, 1, cycles from pst_req_valid to pst_val; fixed at 1 for this revision.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin an evaluation; honoured only in IDLE
abort  input  1  cancels an evaluation in progress; no done is produced
board  input  256  square s occupies bits [4s+3:4s]; bit 3 = colour (1 = black), bits [2:0] = type (0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king, 7 reserved/treated empty)
pst_req_valid  output  1  lookup issued this cycle
pst_type  output  3  piece type of the lookup
pst_sq  output  6  table index, already mirrored for black
pst_val  input  VAL_W  signed table value, valid one cycle after pst_req_valid
busy  output  1  high from the cycle after start is accepted until done or abort
done  output  1  one-cycle pulse when score is updated
score  output  ACC_W  signed result; white-positive; held until the next done

Behaviour:
- Reset (asynchronous): state IDLE; busy=0, done=0, pst_req_valid=0, pst_type=0, pst_sq=0, score=0, accumulator=0, square counter=0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE with start=1 at cycle T:
  - board is latched into an internal snapshot; later board changes are ignored.
  - Accumulator and counter are cleared; next state is ISSUE.
- ISSUE, cycles T+1..T+64, counter sq = 0..63:
  - If the snapshot square is occupied (type 1..6): pst_req_valid=1, pst_type=type, pst_sq = sq for white or sq^6'd56 for black.
  - Otherwise pst_req_valid=0, and pst_type/pst_sq are don't-care and driven 0.
  - Outputs are registered. A one-stage side pipe carries {valid, negate} aligned with pst_val.
  - After sq=63, the next state is DRAIN.
- Accumulate rule, every cycle the side pipe valid=1: acc += negate ? −sext(pst_val) : sext(pst_val), computed at ACC_W bits with no saturation.
- DRAIN, cycle T+65: absorbs the last returned value; next state is DONE.
- DONE, cycle T+66: score<=acc, done=1 for exactly one cycle, busy=0; then IDLE. Total latency start→done is 66 cycles, independent of piece count.
- busy=1 in ISSUE and DRAIN; 0 in IDLE and DONE.
- start while not IDLE: ignored, no queueing. start in the DONE cycle is also ignored; a new start is accepted from IDLE on the following cycle.
- abort in ISSUE or DRAIN: next state IDLE; pst_req_valid drops next cycle; the side pipe is flushed; score is unchanged; no done.
- abort and start in the same cycle while IDLE: abort has priority and the start is dropped.
- Reset mid-evaluation: immediate return to the reset values, including score=0.
- Type 7 is treated as empty, with no lookup.

Decomposition:
- Package chess_eval_pkg holds:
  - piece type codes (EMPTY..KING) and the COLOR_BIT index;
  - SQ_MIRROR = 6'd56;
  - VAL_W/ACC_W defaults;
  - the FSM state enum.
- One natural sub-module: pst_lookup_port, a registered mux over the six flattened 384-bit map buses with 1-cycle latency. It is instantiated beside this block, not inside it.
- The sequencer itself stays a single module.

Test Plan:
- Empty board, start at T → pst_req_valid never asserts; done at T+66, score=0, busy high T+1..T+65.
- White king only at sq 2, king table model (idx2=31) → one request {type=6, sq=2} at T+3; score=+31.
- Black king only at sq 58, same model → request sq=2; score=−31. Black king at sq 61 → sq 5, value −20 → score=+20.
- Standard start position, model returning +1 for every index → 32 requests; score=0. Model returning −32 everywhere → score=0. White-only 16 pieces with −32 everywhere → score=−512.
- abort at T+30 → pst_req_valid low from T+31, busy low at T+31, no done, score retains its prior value; a restart at T+32 completes normally at T+98.
- start pulsed again at T+10 and at T+66 → both ignored, single done. Reset asserted at T+40 → all outputs 0 asynchronously, score=0.
